// File: rtl/decode_pkg.sv
// Shared decode constants: instruction format codes, RV32I major opcodes,
// and the opcode-to-format classifier used by the decode stage.
package decode_pkg;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_UNK = 3'd7;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   // Map a major opcode to its immediate/operand format.
   function automatic logic [2:0] fmt_of(input logic [6:0] op);
      case (op)
         OP_REG:                                          return FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:   return FMT_I;
         OP_STORE:                                        return FMT_S;
         OP_BRANCH:                                       return FMT_B;
         OP_LUI, OP_AUIPC:                                return FMT_U;
         OP_JAL:                                          return FMT_J;
         default:                                         return FMT_UNK;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the format-specific 32-bit
// immediate, then sign-extends it from instruction bit 31 to XLEN.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   // Select and assemble the 32-bit immediate for the decoded format.
   always_comb begin
      // NOTE: default assigned first so no path leaves imm32 unassigned (which would infer a latch).
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // imm32[31] always equals instr[31] for formats carrying an immediate,
   // so a signed widening cast gives the required extension for XLEN=64.
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV32E decode stage with valid/ready handshake on both
// sides, flush, and a one-cycle capture-to-output latency.
// Optional: define DEC_ILLEGAL_CHECK_EN to register an illegal-instruction
// flag with each bundle; otherwise out_illegal is tied to 0.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int PC_W       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [PC_W-1:0]       in_pc,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PC_W-1:0]       out_pc,
   output logic [REG_ADDR_W-1:0] rs1,
   output logic [REG_ADDR_W-1:0] rs2,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [2:0]            f3,
   output logic [6:0]            f7,
   output logic [6:0]            opcode,
   output logic [2:0]            fmt,
   output logic [XLEN-1:0]       imm,
   output logic                  out_illegal
);

   logic                  capture;
   logic [2:0]            fmt_dec;
   logic [XLEN-1:0]       imm_dec;

   logic                  valid_d,  valid_q;
   logic [PC_W-1:0]       pc_d,     pc_q;
   logic [REG_ADDR_W-1:0] rs1_d,    rs1_q;
   logic [REG_ADDR_W-1:0] rs2_d,    rs2_q;
   logic [REG_ADDR_W-1:0] rd_d,     rd_q;
   logic [2:0]            f3_d,     f3_q;
   logic [6:0]            f7_d,     f7_q;
   logic [6:0]            opcode_d, opcode_q;
   logic [2:0]            fmt_d,    fmt_q;
   logic [XLEN-1:0]       imm_d,    imm_q;

   // Ready depends only on flush and the output side, never on in_valid.
   assign in_ready = !flush && (!valid_q || out_ready);
   assign capture  = in_valid && in_ready;

   assign fmt_dec = fmt_of(in_instr[6:0]);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (in_instr),
      .fmt   (fmt_dec),
      .imm   (imm_dec)
   );

   // Next-state: flush beats capture, capture beats hold; drain clears valid only.
   always_comb begin
      valid_d  = valid_q && !out_ready;
      pc_d     = pc_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      f3_d     = f3_q;
      f7_d     = f7_q;
      opcode_d = opcode_q;
      fmt_d    = fmt_q;
      imm_d    = imm_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d  = 1'b1;
         pc_d     = in_pc;
         rs1_d    = in_instr[15 +: REG_ADDR_W];
         rs2_d    = in_instr[20 +: REG_ADDR_W];
         rd_d     = in_instr[7 +: REG_ADDR_W];
         f3_d     = in_instr[14:12];
         f7_d     = in_instr[31:25];
         opcode_d = in_instr[6:0];
         fmt_d    = fmt_dec;
         imm_d    = imm_dec;
      end
   end

   // Pipeline register; reset clears valid and every field (fmt resets to FMT_R).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         valid_q  <= 1'b0;
         pc_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         f3_q     <= '0;
         f7_q     <= '0;
         opcode_q <= '0;
         fmt_q    <= FMT_R;
         imm_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         f3_q     <= f3_d;
         f7_q     <= f7_d;
         opcode_q <= opcode_d;
         fmt_q    <= fmt_d;
         imm_q    <= imm_d;
      end
   end

`ifdef DEC_ILLEGAL_CHECK_EN
   logic illegal_dec;
   logic illegal_d, illegal_q;

   // Classify the incoming word; RV32E rejects bit 4 of any register field the format uses.
   always_comb begin
      logic rd_used, rs1_used, rs2_used;
      rd_used  = (fmt_dec == FMT_R) || (fmt_dec == FMT_I) || (fmt_dec == FMT_U) || (fmt_dec == FMT_J);
      rs1_used = (fmt_dec == FMT_R) || (fmt_dec == FMT_I) || (fmt_dec == FMT_S) || (fmt_dec == FMT_B);
      rs2_used = (fmt_dec == FMT_R) || (fmt_dec == FMT_S) || (fmt_dec == FMT_B);
      illegal_dec = (fmt_dec == FMT_UNK) || (in_instr[1:0] != 2'b11);
      if ((fmt_dec == FMT_R) && (in_instr[31:25] != 7'b0000000) && (in_instr[31:25] != 7'b0100000))
         illegal_dec = 1'b1;
      if ((REG_ADDR_W == 4) &&
          ((rd_used && in_instr[11]) || (rs1_used && in_instr[19]) || (rs2_used && in_instr[24])))
         illegal_dec = 1'b1;
   end

   // The flag travels with the bundle: loaded only on capture.
   always_comb begin
      illegal_d = illegal_q;
      if (!flush && capture) illegal_d = illegal_dec;
   end

   // Illegal flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end

   assign out_illegal = illegal_q;
`else
   assign out_illegal = 1'b0;
`endif

   assign out_valid = valid_q;
   assign out_pc    = pc_q;
   assign rs1       = rs1_q;
   assign rs2       = rs2_q;
   assign rd        = rd_q;
   assign f3        = f3_q;
   assign f7        = f7_q;
   assign opcode    = opcode_q;
   assign fmt       = fmt_q;
   assign imm       = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan vectors, stall,
// flush, asynchronous reset, and randomized traffic against a behavioural model.
module tb_decode_stage;

   localparam int XLEN  = 32;
   localparam int PC_W  = 32;
   localparam int REG_W = 5;

   typedef struct packed {
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [2:0]       f3;
      logic [6:0]       f7;
      logic [6:0]       op;
      logic [2:0]       fmt;
      logic [XLEN-1:0]  imm;
      logic             ill;
   } bundle_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc, out_pc;
   logic [REG_W-1:0]  rs1, rs2, rd;
   logic [2:0]        f3, fmt;
   logic [6:0]        f7, opcode;
   logic [XLEN-1:0]   imm;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bundle_t         exp_b;
   logic            exp_valid;
   logic [PC_W-1:0] exp_pc;
   logic            exp_ready, obs_ready;

   decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .REG_ADDR_W(REG_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
      .f3(f3), .f7(f7), .opcode(opcode), .fmt(fmt), .imm(imm), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] m_fmt(input logic [6:0] op);
      case (op)
         7'h33:                              return 3'd0;
         7'h13, 7'h03, 7'h67, 7'h73, 7'h0F:  return 3'd1;
         7'h23:                              return 3'd2;
         7'h63:                              return 3'd3;
         7'h37, 7'h17:                       return 3'd4;
         7'h6F:                              return 3'd5;
         default:                            return 3'd7;
      endcase
   endfunction

   // Immediates built with signed integer shifts rather than bit concatenation.
   function automatic logic [31:0] m_imm(input logic [31:0] w, input logic [2:0] f);
      int s;
      s = int'(w);
      case (f)
         3'd1: return 32'(s >>> 20);
         3'd2: return 32'(((s >>> 25) <<< 5) | int'(w[11:7]));
         3'd3: return 32'(((s >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1));
         3'd4: return 32'(s & 32'hFFFFF000);
         3'd5: return 32'(((s >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1));
         default: return 32'd0;
      endcase
   endfunction

   function automatic bundle_t m_decode(input logic [31:0] w);
      bundle_t b;
      b.rs1 = w[15 +: REG_W];
      b.rs2 = w[20 +: REG_W];
      b.rd  = w[7 +: REG_W];
      b.f3  = w[14:12];
      b.f7  = w[31:25];
      b.op  = w[6:0];
      b.fmt = m_fmt(w[6:0]);
      b.imm = m_imm(w, b.fmt);
      b.ill = 1'b0;
`ifdef DEC_ILLEGAL_CHECK_EN
      if (b.fmt == 3'd7 || w[1:0] != 2'b11) b.ill = 1'b1;
      if (b.fmt == 3'd0 && !(w[31:25] inside {7'h00, 7'h20})) b.ill = 1'b1;
      if (REG_W == 4) begin
         if ((b.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && w[11]) b.ill = 1'b1;
         if ((b.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) && w[19]) b.ill = 1'b1;
         if ((b.fmt inside {3'd0, 3'd2, 3'd3}) && w[24]) b.ill = 1'b1;
      end
`endif
      return b;
   endfunction

   function automatic bundle_t get_obs();
      bundle_t b;
      b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.f3 = f3; b.f7 = f7;
      b.op = opcode; b.fmt = fmt; b.imm = imm; b.ill = out_illegal;
      return b;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 12))
         0:  w[6:0] = 7'h33;
         1:  w[6:0] = 7'h13;
         2:  w[6:0] = 7'h03;
         3:  w[6:0] = 7'h23;
         4:  w[6:0] = 7'h63;
         5:  w[6:0] = 7'h6F;
         6:  w[6:0] = 7'h67;
         7:  w[6:0] = 7'h37;
         8:  w[6:0] = 7'h17;
         9:  w[6:0] = 7'h73;
         10: w[6:0] = 7'h0F;
         default: ;
      endcase
      return w;
   endfunction

   task automatic model_reset();
      exp_b     = '0;
      exp_valid = 1'b0;
      exp_pc    = '0;
   endtask

   // Drive one cycle: apply inputs, sample in_ready before the edge, advance model, settle.
   task automatic tick(input logic v, input logic [31:0] w, input logic [PC_W-1:0] pc,
                       input logic rdy, input logic fl);
      in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
      exp_ready = !fl && (!exp_valid || rdy);
      #1;
      obs_ready = in_ready;
      @(posedge clk);
      if (fl) exp_valid = 1'b0;
      else if (v && exp_ready) begin
         exp_valid = 1'b1;
         exp_b     = m_decode(w);
         exp_pc    = pc;
      end else if (rdy) exp_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 0; in_instr = 32'hFFFF_FFFF; in_pc = '1; out_ready = 1; flush = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (get_obs() !== bundle_t'('0)) begin errors++; $display("FAIL reset_fields: got %0h expected 0", get_obs()); end
      checks++; if (out_pc !== '0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", out_pc); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] w  [5] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h001000EF, 32'h123452B7};
      logic [2:0]  ef [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
      logic [4:0]  erd[5] = '{5'd1, 5'd8, 5'd29, 5'd1, 5'd5};
      logic [31:0] ei [5] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h800, 32'h12345000};
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, w[i], 32'h100 + 4 * i, 1'b1, 1'b0);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %0b expected 1", i, out_valid); end
         checks++; if (fmt !== ef[i]) begin errors++; $display("FAIL dir%0d_fmt: got %0d expected %0d", i, fmt, ef[i]); end
         checks++; if (rd !== erd[i]) begin errors++; $display("FAIL dir%0d_rd: got %0d expected %0d", i, rd, erd[i]); end
         checks++; if (imm !== ei[i]) begin errors++; $display("FAIL dir%0d_imm: got %0h expected %0h", i, imm, ei[i]); end
         checks++; if (out_pc !== 32'h100 + 4 * i) begin errors++; $display("FAIL dir%0d_pc: got %0h expected %0h", i, out_pc, 32'h100 + 4 * i); end
         if (i == 0) begin
            checks++; if (rs1 !== 5'd0) begin errors++; $display("FAIL addi_rs1: got %0d expected 0", rs1); end
         end
         if (i == 1) begin
            checks++; if ({rs1, rs2, f3} !== {5'd1, 5'd2, 3'd2})
               begin errors++; $display("FAIL sw_fields: got rs1=%0d rs2=%0d f3=%0d expected 1 2 2", rs1, rs2, f3); end
         end
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %0b expected 0", out_valid); end
      checks++; if (imm !== 32'h12345000) begin errors++; $display("FAIL drain_keep: got %0h expected 12345000", imm); end
   endtask

   task automatic test_stall();
      tick(1'b1, 32'hFFF00093, 32'hA0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 32'h123452B7, 32'hA4, 1'b0, 1'b0);
         checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_ready: got %0b expected 0", i, obs_ready); end
         checks++; if ({out_valid, out_pc, imm} !== {1'b1, 32'hA0, 32'hFFFFFFFF})
            begin errors++; $display("FAIL stall%0d_hold: got v=%0b pc=%0h imm=%0h expected 1 a0 ffffffff", i, out_valid, out_pc, imm); end
      end
      tick(1'b1, 32'h123452B7, 32'hA4, 1'b1, 1'b0);
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0b expected 1", obs_ready); end
      checks++; if ({out_valid, out_pc, imm, fmt} !== {1'b1, 32'hA4, 32'h12345000, 3'd4})
         begin errors++; $display("FAIL release_new: got v=%0b pc=%0h imm=%0h fmt=%0d expected 1 a4 12345000 4", out_valid, out_pc, imm, fmt); end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_flush();
      tick(1'b1, 32'h0020A423, 32'hB0, 1'b1, 1'b0);
      tick(1'b1, 32'h001000EF, 32'hB4, 1'b0, 1'b1);
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b expected 0", obs_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: got %0b expected 0", out_valid); end
      tick(1'b1, 32'hFE000EE3, 32'hB8, 1'b1, 1'b1);
      checks++; if ({out_valid, out_pc, fmt} !== {1'b0, 32'hB0, 3'd2})
         begin errors++; $display("FAIL flush_capture: got v=%0b pc=%0h fmt=%0d expected 0 b0 2", out_valid, out_pc, fmt); end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %0b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      tick(1'b1, 32'hFFF00093, 32'hC0, 1'b1, 1'b0);
      tick(1'b1, 32'h123452B7, 32'hC4, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async: got %0b expected 0", out_valid); end
      in_valid = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      checks++; if ({out_valid, out_pc, get_obs()} !== '0)
         begin errors++; $display("FAIL rst_clear: got v=%0b pc=%0h f=%0h expected 0", out_valid, out_pc, get_obs()); end
   endtask

`ifdef DEC_ILLEGAL_CHECK_EN
   task automatic test_illegal();
      logic [31:0] w [3] = '{32'h00000000, 32'hFFF00093, 32'h02000033};
      logic        e [3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, w[i], 32'hD0, 1'b1, 1'b0);
         checks++; if (out_illegal !== e[i]) begin errors++; $display("FAIL illegal%0d: got %0b expected %0b", i, out_illegal, e[i]); end
      end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask
`endif

   task automatic test_random();
      logic v, r, f;
      for (int i = 0; i < 800; i++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 19) == 0);
         tick(v, rand_instr(), PC_W'($urandom), r, f);
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd%0d_ready: got %0b expected %0b", i, obs_ready, exp_ready); end
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd%0d_valid: got %0b expected %0b", i, out_valid, exp_valid); end
         checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL rnd%0d_pc: got %0h expected %0h", i, out_pc, exp_pc); end
         checks++; if (get_obs() !== exp_b) begin errors++; $display("FAIL rnd%0d_bundle: got %0h expected %0h", i, get_obs(), exp_b); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_flush();
      test_reset_mid();
`ifdef DEC_ILLEGAL_CHECK_EN
      test_illegal();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I instruction-decode pipeline stage. It sits between fetch and execute, with a valid/ready handshake on both sides. It extracts the register and function fields, classifies the instruction format, and generates the sign-extended immediate in the same cycle as the capture. It supports stall, flush and an RV32E register-file mode through parameters.

Parameters:
- XLEN, 32, datapath and immediate width; legal values are 32 and 64; immediates sign-extend to XLEN.
- PC_W, 32, width of the program-counter sideband carried through the stage.
- REG_ADDR_W, 5, register index width; 5 selects RV32I, 4 selects RV32E; field outputs carry the low REG_ADDR_W bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  PC_W  registered PC.
- rs1, rs2, rd  out  REG_ADDR_W  register indices.
- f3  out  3  funct3.
- f7  out  7  funct7.
- opcode  out  7  opcode.
- fmt  out  3  format code.
- imm  out  XLEN  decoded immediate.
- out_illegal  out  1  illegal-instruction flag.

Behaviour:
- Reset (asynchronous assert, synchronous-clean release): out_valid=0, every output register=0, fmt=FMT_R (0).
- in_ready = !flush && (!out_valid || out_ready). It is combinational and has no dependency on in_valid.
- Capture occurs when in_valid && in_ready. On the next edge, all outputs update and out_valid=1. Latency is 1 cycle, and throughput is 1 instruction per cycle with out_ready held high.
- Hold: while out_valid && !out_ready, all outputs stay bit-stable and no capture occurs.
- Drain: out_valid && out_ready with no capture sets out_valid=0 next cycle. Data registers keep their last values.
- Flush: out_valid=0 next edge, and nothing is captured that cycle. Flush has priority over capture and over hold. Flush on an empty stage is harmless.
- Reset mid-transfer: the bundle is discarded, and out_valid is 0 immediately on assertion.
- Field slices, taken from the captured word:
  - rs1=[15+:REG_ADDR_W]
  - rs2=[20+:REG_ADDR_W]
  - rd=[7+:REG_ADDR_W]
  - f3=[14:12]
  - f7=[31:25]
  - opcode=[6:0]
- fmt by opcode:
  - 0110011 → R(0)
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I(1)
  - 0100011 → S(2)
  - 1100011 → B(3)
  - 0110111, 0010111 → U(4)
  - 1101111 → J(5)
  - else → UNK(7)
- imm by format:
  - I: sext([31:20])
  - S: sext({[31:25],[11:7]})
  - B: sext({[31],[7],[30:25],[11:8],1'b0})
  - U: sext({[31:12],12'b0})
  - J: sext({[31],[19:12],[20],[30:21],1'b0})
  - R/UNK: 0
  - All sign extension is from bit 31 of the instruction to XLEN.
- Decode logic is combinational on in_instr and registered at capture. There is no decode in the output path.

Optional Feature:
DEC_ILLEGAL_CHECK_EN.
- Defined: out_illegal is registered with the bundle and set when any of the following holds:
  - fmt==UNK;
  - in_instr[1:0]!=2'b11;
  - R-type with f7 not in {0000000, 0100000};
  - REG_ADDR_W==4 and bit 4 of any used register field is set (rd for I/U/J/R; rs1 for R/I/S/B; rs2 for R/S/B).
  - Field outputs are still produced as normal.
- Undefined: out_illegal is constant 0, and the port is still present.

Decomposition:
- Package decode_pkg: fmt localparams FMT_R/I/S/B/U/J/UNK (3-bit), opcode localparams (OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_FENCE).
- Sub-module imm_gen: combinational, inputs instr[31:0] and fmt, output imm[XLEN-1:0]. It is instantiated once, ahead of the pipeline register.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF.
- 0x0020A423 (sw x2,8(x1)) → fmt=2, rs1=1, rs2=2, f3=2, imm=8. Then 0xFE000EE3 (beq -4) → fmt=3, imm=0xFFFFFFFC.
- 0x001000EF (jal x1,2048) → fmt=5, rd=1, imm=0x800. 0x123452B7 (lui x5) → fmt=4, rd=5, imm=0x12345000.
- Stall: out_ready=0 for 3 cycles with in_valid=1 and a new instruction → in_ready=0, outputs unchanged. Release → old bundle accepted, new bundle valid the following cycle.
- Flush asserted in a capture cycle → out_valid=0 next cycle, and the captured instruction never appears. rst pulsed mid-stall → out_valid drops asynchronously.
- With DEC_ILLEGAL_CHECK_EN: 0x00000000 → out_illegal=1. REG_ADDR_W=4 with 0x01000093 (rd=1, rs1=0, imm=16) → illegal=0; rd=17 → illegal=1.
